seq_mult_scan_display: RTL and testbench
========================================

SEQ_MULT_SCAN_DISPLAY -- requirements
Module: seq_mult_scan_display

Interface
REQ-001 Parameter W, default 4, operand width in bits; SHALL be a multiple of 4, range 4..16.
REQ-002 Parameter REFRESH_BITS, default 16, log2 of clock cycles each display digit stays lit.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 start  input  1  request a multiply; sampled only in IDLE.
REQ-006 sgn  input  1  0 = unsigned, 1 = two's-complement; sampled with start.
REQ-007 a  input  W  multiplicand; b  input  W  multiplier.
REQ-008 p  output  2W  product register.
REQ-009 busy  output  1  high while a multiply is in progress.
REQ-010 done  output  1  one-cycle pulse when p is updated.
REQ-011 an  output  W  digit enables, active-low, one-hot-low; an[W-1] is the leftmost digit.
REQ-012 ca  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 FSM states: IDLE, RUN, DONE. IDLE->RUN on start=1; RUN->DONE after exactly W RUN cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-014 Start accepted at edge T: latch a, b, sgn; busy=1 for edges T+1..T+W; at edge T+W+1, p updates, done=1 for one cycle and busy=0.
REQ-015 Latency is W+1 cycles from accepting start to done, identical in both modes.
REQ-016 start while busy or in DONE SHALL be ignored: no re-latch, no extension.
REQ-017 start held high SHALL begin a new multiply on the first IDLE cycle after DONE.
REQ-018 Core: shift-add, one multiplier bit per RUN cycle, over operand magnitudes.
REQ-019 Signed mode: magnitudes via two's-complement negation of negative operands; product negated in DONE when signs differ.
REQ-020 -2^(W-1) x -2^(W-1) SHALL give +2^(2W-2) with no overflow; all results are exact in 2W bits.
REQ-021 p SHALL hold its value until the next DONE; it SHALL NOT change during RUN.
REQ-022 Display value: the 4W-bit concatenation {a, b, p}, with live a and b inputs, split into W hex digits, most significant on an[W-1].
REQ-023 While busy=1, the 2W/4 product digits SHALL show "-" (ca = 7'b0111111); operand digits stay live.
REQ-024 Scan: free-running REFRESH_BITS-bit counter; digit index advances on counter wrap, from 0 (an[0]) upward, wrapping W-1 -> 0.
REQ-025 Hex decode, active-low: 0..F -> standard 7-segment glyphs with lowercase b and d.
REQ-026 an and ca SHALL be registered, with no combinational path from a, b or p to the outputs.

Reset
REQ-027 clr=0 SHALL immediately force: state IDLE, p=0, busy=0, done=0, scan counter and digit index 0, an all ones, ca all ones.
REQ-028 Reset during RUN SHALL abort the multiply with no done pulse; after release the FSM is IDLE and the first lit digit is an[0].

Structure
REQ-029 Package seq_mult_pkg SHALL hold the FSM state type, the 16-entry hex-to-segment table, and the dash glyph constant.
REQ-030 Sub-module seg7_scan SHALL implement the scan counter, digit mux, blanking and decode; the multiplier FSM stays in the top module.

Verification (W=4, REFRESH_BITS=2)
REQ-031 Unsigned case: sgn=0, a=F, b=F, start at T -> busy T+1..T+4; at T+5, p=8'hE1 and done pulses.
REQ-032 Signed corners: sgn=1, a=8, b=8 -> p=8'h40; sgn=1, a=D(-3), b=5 -> p=8'hF1 (-15); sgn=1, a=0, b=8 -> p=8'h00.
REQ-033 Start during busy: pulse start at T+2 with new a/b -> result matches the original operands; exactly one done pulse.
REQ-034 Reset mid-operation: clr=0 at T+2 -> p=0, busy=0, no done; a new start afterwards completes normally.
REQ-035 Display: a=3, b=2, p=8'h06 -> an sequence 1110,1101,1011,0111 every 4 cycles with ca = decode of 6,0,2,3; while busy, product digits show the dash.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential multiplier with scanned hex display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Lowercase b and d keep them distinct from 8 and 0.
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seq_mult_scan_display_seg7_scan.sv
// Time-multiplexed 7-segment driver: one digit lit per refresh period, product
// digits replaced by a dash while a multiply is running.
module seg7_scan
    import seq_mult_pkg::*;
#(
    parameter int W            = 4,
    parameter int REFRESH_BITS = 16
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           busy,
    input  logic [4*W-1:0] value,
    output logic [W-1:0]   an,
    output logic [6:0]     ca
);

    localparam int IDX_W       = $clog2(W);
    localparam int PROD_DIGITS = W / 2;

    logic [REFRESH_BITS-1:0] cnt_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [IDX_W-1:0]        idx_next;
    logic [W-1:0]            an_reg;
    logic [W-1:0]            an_next;
    logic [6:0]              ca_reg;
    logic [6:0]              ca_next;
    logic [3:0]              digit [W];
    logic [3:0]              nibble;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_digit
            assign digit[gi]   = value[4*gi +: 4];
            assign an_next[gi] = (idx_reg != IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        idx_next = idx_reg;
        if (&cnt_reg) begin
            idx_next = (idx_reg == IDX_W'(W - 1)) ? '0 : idx_reg + 1'b1;
        end
        nibble  = digit[idx_reg];
        ca_next = hex_to_seg(nibble);
        if (busy && (idx_reg < IDX_W'(PROD_DIGITS))) begin
            ca_next = SEG_DASH;
        end
    end

    // Outputs are registered so the pins never see a combinational path from a, b or p.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            an_reg  <= '1;
            ca_reg  <= SEG_BLANK;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            idx_reg <= idx_next;
            an_reg  <= an_next;
            ca_reg  <= ca_next;
        end
    end

    assign an = an_reg;
    assign ca = ca_reg;

endmodule

// File: rtl/seq_mult_scan_display.sv
// Shift-add sequential multiplier (unsigned or two's-complement) whose operands
// and product are shown on a scanned W-digit hex display.
module seq_mult_scan_display
    import seq_mult_pkg::*;
#(
    parameter int W            = 4,
    parameter int REFRESH_BITS = 16
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   an,
    output logic [6:0]     ca
);

    localparam int CNT_W = $clog2(W);

    state_t           state_reg;
    state_t           state_next;
    logic [2*W-1:0]   acc_reg;
    logic [2*W-1:0]   mcand_reg;
    logic [W-1:0]     mplier_reg;
    logic             neg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2*W-1:0]   p_reg;
    logic             done_reg;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic [2*W-1:0]   p_next;

    always_comb begin
        mag_a = a;
        mag_b = b;
        if (sgn && a[W-1]) begin
            mag_a = ~a + 1'b1;
        end
        if (sgn && b[W-1]) begin
            mag_b = ~b + 1'b1;
        end
    end

    // The magnitude of -2^(W-1) still fits in W unsigned bits, so the
    // 2W-bit accumulator holds every product exactly.
    assign p_next = neg_reg ? (~acc_reg + 1'b1) : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt_reg == CNT_W'(W - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            p_reg      <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg    <= '0;
                        mcand_reg  <= {{W{1'b0}}, mag_a};
                        mplier_reg <= mag_b;
                        neg_reg    <= sgn && (a[W-1] ^ b[W-1]);
                        cnt_reg    <= '0;
                    end
                end
                RUN: begin
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                end
                DONE: begin
                    p_reg    <= p_next;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign p    = p_reg;
    assign done = done_reg;
    assign busy = (state_reg == RUN);

    seg7_scan #(
        .W            (W),
        .REFRESH_BITS (REFRESH_BITS)
    ) u_scan (
        .clk   (clk),
        .clr   (clr),
        .busy  (busy),
        .value ({a, b, p_reg}),
        .an    (an),
        .ca    (ca)
    );

endmodule

// File: tb/tb_seq_mult_scan_display.sv
// Self-checking bench: cycle-accurate behavioural model compared every cycle,
// plus directed literal checks and randomized multiplies with occasional resets.
module tb_seq_mult_scan_display;

    localparam int W  = 4;
    localparam int RB = 2;

    logic           clk;
    logic           clr;
    logic           start;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;
    logic [W-1:0]   an;
    logic [6:0]     ca;

    int checks   = 0;
    int failures = 0;

    seq_mult_scan_display #(.W(W), .REFRESH_BITS(RB)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .ca    (ca)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                                   input logic s);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        if (s && x[W-1]) xi = xi - (1 << W);
        if (s && y[W-1]) yi = yi - (1 << W);
        return (2*W)'(xi * yi);
    endfunction

    int             m_ph;
    int             m_k;
    logic [2*W-1:0] m_res;
    logic [2*W-1:0] m_p;
    logic           m_done;
    logic [W-1:0]   m_an;
    logic [6:0]     m_ca;
    logic           m_busy;

    assign m_busy = (m_ph >= 1) && (m_ph <= W);

    function automatic logic [6:0] exp_seg(input int d, input logic bsy, input logic [2*W-1:0] pv);
        logic [4*W-1:0] v;
        v = {a, b, pv};
        if (bsy && (d < W / 2)) return 7'h3F;
        return glyph[v[4*d +: 4]];
    endfunction

    // m_ph: 0 idle, 1..W cycles after acceptance, W+1 the cycle before the result lands.
    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_ph   <= 0;
            m_k    <= 0;
            m_res  <= '0;
            m_p    <= '0;
            m_done <= 1'b0;
            m_an   <= '1;
            m_ca   <= 7'h7F;
        end else begin
            m_an   <= ~(W'(1) << ((m_k >> RB) % W));
            m_ca   <= exp_seg((m_k >> RB) % W, m_busy, m_p);
            m_k    <= m_k + 1;
            m_done <= 1'b0;
            if (m_ph == 0) begin
                if (start) begin
                    m_ph  <= 1;
                    m_res <= ref_product(a, b, sgn);
                end
            end else if (m_ph <= W) begin
                m_ph <= m_ph + 1;
            end else begin
                m_ph   <= 0;
                m_p    <= m_res;
                m_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_p", 32'(p), 32'(m_p));
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_an", 32'(an), 32'(m_an));
        chk("cyc_ca", 32'(ca), 32'(m_ca));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mult_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input logic [2*W-1:0] exp_p);
        int n;
        a = x; b = y; sgn = s; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
        chk({name, "_p"}, 32'(p), 32'(exp_p));
        tick();
    endtask

    task automatic wait_an(input logic [W-1:0] pat, input logic [6:0] exp_ca, input string name);
        int n;
        n = 0;
        while (an !== pat && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_an"}, 32'(an), 32'(pat));
        chk({name, "_ca"}, 32'(ca), 32'(exp_ca));
    endtask

    initial begin
        int dones;
        clr = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        chk("rst_p", 32'(p), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_ca", 32'(ca), 32'h7F);
        clr = 1'b1;
        tick();

        // Unsigned F x F with exact timing
        a = 4'hF; b = 4'hF; sgn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk("u_busy_run", 32'(busy), 32'd1);
            if (i < W - 1) tick();
        end
        tick();
        chk("u_busy_low", 32'(busy), 32'd0);
        chk("u_done_early", 32'(done), 32'd0);
        tick();
        chk("u_done", 32'(done), 32'd1);
        chk("u_p", 32'(p), 32'hE1);
        tick();
        chk("u_done_pulse", 32'(done), 32'd0);

        mult_lit("s_8x8", 4'h8, 4'h8, 1'b1, 8'h40);
        mult_lit("s_Dx5", 4'hD, 4'h5, 1'b1, 8'hF1);
        mult_lit("s_0x8", 4'h0, 4'h8, 1'b1, 8'h00);

        // Start while busy is ignored
        a = 4'h7; b = 4'h3; sgn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'hF; b = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) begin
                dones++;
                chk("busy_start_p", 32'(p), 32'h15);
            end
            tick();
        end
        chk("busy_start_dones", 32'(dones), 32'd1);

        // Reset mid-operation
        a = 4'hF; b = 4'hF; sgn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b0;
        tick();
        chk("abort_p", 32'(p), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        clr = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        mult_lit("after_abort", 4'h5, 4'h3, 1'b0, 8'h0F);

        // Display of {3,2,06}
        mult_lit("disp", 4'h3, 4'h2, 1'b0, 8'h06);
        wait_an(4'b1110, 7'h02, "disp_d0");
        wait_an(4'b1101, 7'h40, "disp_d1");
        wait_an(4'b1011, 7'h24, "disp_d2");
        wait_an(4'b0111, 7'h30, "disp_d3");

        // Dash on product digit right after a reset-aligned start
        clr = 1'b0;
        tick();
        clr = 1'b1; a = 4'h3; b = 4'h2; sgn = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("dash_an", 32'(an), 32'hE);
        chk("dash_ca", 32'(ca), 32'h3F);
        repeat (8) tick();

        // Randomized traffic, including held start and occasional resets
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            sgn   = 1'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
            clr   = ($urandom_range(0, 79) != 0);
            tick();
        end
        clr = 1'b1;
        start = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
